// File: rtl/bram_18_7_stream_ctrl.sv
// Stream client for a 1-cycle-latency dual-port BRAM: loads one DEPTH-word frame, then drains it back out.
// Latency: first output word valid 2 cycles after the load phase ends; 1 word/cycle sustained afterwards.
// Backpressure: in_ready is low while draining; out_ready=0 fills a 2-entry skid FIFO and then stalls read issue.
// Optional build macro BRAM_STREAM_BITREV_EN: drain in bit-reversed address order (needs DEPTH == 2**ADDR_W).
module bram_18_7_stream_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_din,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_dout
);

  typedef enum logic {S_LOAD = 1'b0, S_UNLOAD = 1'b1} state_t;

  // Read counter needs one extra bit so "all reads issued" (rd_cnt == DEPTH) is representable.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(DEPTH - 1);

`ifdef BRAM_STREAM_BITREV_EN
  // Bit-reversed draining only makes sense over a full power-of-two address space.
  if (DEPTH != (2 ** ADDR_W)) begin : g_bitrev_depth_chk
    $error("BRAM_STREAM_BITREV_EN requires DEPTH == 2**ADDR_W");
  end
`endif

  state_t              state;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    rd_nxt;
  logic                inflight;
  logic [1:0]          skid_cnt;
  logic [DATA_W-1:0]   skid_tail;
  logic                wr_fire;
  logic                push;
  logic                pop;
  logic                issue;
  logic                last_pop;

  // Maps a frame index to the BRAM address it is read from.
  function automatic logic [ADDR_W-1:0] rd_map(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] r;
`ifdef BRAM_STREAM_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = idx[ADDR_W-1-i];
    end
`else
    r = idx;
`endif
    return r;
  endfunction

  // Write side is a straight pass-through of the accepted input word.
  assign wr_fire     = in_valid & in_ready;
  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_cnt;
  assign mem_wr_din  = in_ready ? in_data : '0;

  assign out_valid = (skid_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign rd_nxt    = rd_cnt + CNT_W'(1);

  // Issue a read when the skid FIFO is guaranteed a free slot at return time; counting this
  // cycle's pop as a freed slot is what keeps the drain at one word per cycle without bubbles.
  always_comb begin
    issue    = 1'b0;
    last_pop = 1'b0;
    if (state == S_UNLOAD) begin
      issue = (rd_cnt < DEPTH_C) &&
              (({1'b0, skid_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
      // Last word leaves when every read is done, nothing is in flight and one word remains.
      last_pop = pop && (rd_cnt == DEPTH_C) && !inflight && (skid_cnt == 2'd1);
    end
  end

  // Phase FSM with load/read counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      in_ready    <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      mem_rd_addr <= '0;
      inflight    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= last_pop;
      inflight   <= issue;
      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (wr_fire) begin
            if (wr_cnt == LAST_WR) begin
              wr_cnt   <= '0;
              state    <= S_UNLOAD;
              in_ready <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + ADDR_W'(1);
            end
          end
        end
        S_UNLOAD: begin
          in_ready <= 1'b0;
          if (issue) begin
            rd_cnt <= rd_nxt;
            // Present the next address early; after the final read the address simply holds.
            if (rd_nxt < DEPTH_C) begin
              mem_rd_addr <= rd_map(rd_nxt[ADDR_W-1:0]);
            end
          end
          if (last_pop) begin
            state       <= S_LOAD;
            rd_cnt      <= '0;
            mem_rd_addr <= rd_map('0);
            in_ready    <= 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Two-entry skid FIFO; out_data is the registered head, skid_tail the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt  <= 2'd0;
      out_data  <= '0;
      skid_tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            out_data <= mem_rd_dout;
          end else begin
            skid_tail <= mem_rd_dout;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          if (skid_cnt == 2'd2) begin
            out_data <= skid_tail;
          end
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            out_data <= mem_rd_dout;
          end else begin
            out_data  <= skid_tail;
            skid_tail <= mem_rd_dout;
          end
        end
        default: begin
          skid_cnt <= skid_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_18_7_stream_ctrl.sv
// Bench for bram_18_7_stream_ctrl: behavioural BRAM, table of frame scenarios, scoreboard on the output stream.
// Latency: checks first word 2 cycles after drain start and gap-free drain when out_ready is held high.
// Backpressure: random and fixed out_ready stalls; output must hold stable until accepted.
module tb_bram_18_7_stream_ctrl;

  localparam int DW    = 18;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          frame_done;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_din;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_dout;

  bram_18_7_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_din (mem_wr_din),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_dout(mem_rd_dout)
  );

  // Behavioural 128x18 BRAM with registered read address.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) bram[mem_wr_addr] <= mem_wr_din;
    mem_rd_dout <= bram[mem_rd_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int base;       // first data value of the frame
    int gap;        // in_valid low every gap-th cycle (0 = never)
    int pct;        // 100 = out_ready held high, otherwise random 50%
    int stall;      // out_ready forced low for this many cycles at drain start
    int stop_after; // number of output words to take before returning
    int exp_lat;    // expected cycles from drain start to first out_valid
    int exp_hold;   // frame index whose address mem_rd_addr must sit on during a stall
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int wr_exp  = 0;
  int wr_base = 0;
  int fd_cnt  = 0;
  int frames_exp = 0;
  logic prev_hold = 1'b0;
  logic prev_fd   = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference read order: natural, or bit-reversed in the reordering build.
  function automatic int tb_map(input int i);
    int r;
`ifdef BRAM_STREAM_BITREV_EN
    r = 0;
    for (int b = 0; b < AW; b++) begin
      if (((i >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    end
`else
    r = i;
`endif
    return r;
  endfunction

  // Monitor: scoreboard pops, hold-stability, frame_done width and dense write addresses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_fd   = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      end
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_width", prev_fd, 0);
      end
      prev_fd = frame_done;
      if (mem_wr_en) begin
        chk("wr_addr", mem_wr_addr, wr_exp);
        chk("wr_din", mem_wr_din, DW'(wr_base + wr_exp));
        wr_exp = (wr_exp + 1) % DEPTH;
      end
    end
  end

  // Entered and left just after a rising edge; loads DEPTH words base..base+DEPTH-1.
  task automatic load_frame(input int base, input int gap);
    int k = 0;
    int cyc = 0;
    logic acc;
    wr_base = base;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'(base + tb_map(i)));
    while (k < DEPTH && cyc < 3000) begin
      in_valid = (gap == 0) || ((cyc % gap) != (gap - 1));
      in_data  = DW'(base + k);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_words", k, DEPTH);
  endtask

  // Entered just after the edge that accepted the last input word.
  task automatic drain_frame(input vec_t v);
    int c = 0;
    int words = 0;
    int first = -1;
    int bub = 0;
    while (words < v.stop_after && c < 3000) begin
      if (c < v.stall) out_ready = 1'b0;
      else if (v.pct == 100) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) chk("in_ready_drop", in_ready, 0);
      if (out_valid && first < 0) first = c;
      if (v.stall > 0 && c == v.stall) begin
        chk("stall_rd_addr", mem_rd_addr, tb_map(v.exp_hold));
        chk("stall_valid", out_valid, 1);
      end
      if (v.pct == 100 && c >= v.stall && c >= 2 && !out_valid) bub++;
      if (out_valid && out_ready) words++;
      c++;
      @(posedge clk);
      #1;
    end
    chk("drain_words", words, v.stop_after);
    chk("first_valid_lat", first, v.exp_lat);
    if (v.pct == 100) chk("drain_bubbles", bub, 0);
    if (v.stop_after == DEPTH) begin
      frames_exp++;
      @(negedge clk);
      chk("frame_done_pulse", frame_done, 1);
      chk("in_ready_back", in_ready, 1);
      @(posedge clk);
      #1;
      chk("sb_empty", exp_q.size(), 0);
      chk("frame_count", fd_cnt, frames_exp);
    end
  endtask

  vec_t vecs[4];
  vec_t vr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 0,   gap: 0, pct: 100, stall: 0,  stop_after: DEPTH, exp_lat: 2, exp_hold: 0};
    vecs[1] = '{base: 200, gap: 3, pct: 50,  stall: 0,  stop_after: DEPTH, exp_lat: 2, exp_hold: 0};
    vecs[2] = '{base: 400, gap: 0, pct: 100, stall: 10, stop_after: DEPTH, exp_lat: 2, exp_hold: 2};
    vecs[3] = '{base: 600, gap: 3, pct: 50,  stall: 10, stop_after: DEPTH, exp_lat: 2, exp_hold: 2};

    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(5);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_din", mem_wr_din, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load_frame(vecs[i].base, vecs[i].gap);
      drain_frame(vecs[i]);
    end

    // Reset in the middle of a drain, after 40 words have left.
    vr = '{base: 800, gap: 0, pct: 100, stall: 0, stop_after: 40, exp_lat: 2, exp_hold: 0};
    load_frame(vr.base, vr.gap);
    drain_frame(vr);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_frame_done", frame_done, 0);
    exp_q.delete();
    wr_exp = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    vr = '{base: 1000, gap: 0, pct: 100, stall: 0, stop_after: DEPTH, exp_lat: 2, exp_hold: 0};
    load_frame(vr.base, vr.gap);
    drain_frame(vr);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_18_7_stream_ctrl.md
Name: bram_18_7_stream_ctrl

Overview:
- Stream-side client for the 128x18 dual-port coefficient BRAM, which has a registered read address and 1-cycle read latency.
- Loads one frame of DEPTH words from an input valid/ready stream into the BRAM at sequential addresses.
- Then drains the frame back out on an output valid/ready stream under full backpressure.
- Sits between the NTT input/output FIFOs and the coefficient memory. Its BRAM-side ports connect directly to the memory's wr_en/wr_addr/rd_addr/wr_din/rd_dout.

Parameters:
DATA_W, 18, coefficient width; must match the BRAM word width
ADDR_W, 7, BRAM address width
DEPTH, 128, words per frame; 2 <= DEPTH <= 2**ADDR_W

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  controller accepts input word
in_data  input  DATA_W  input coefficient
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts output word
out_data  output  DATA_W  output coefficient
frame_done  output  1  1-cycle pulse when the last word of a frame is accepted on output
mem_wr_en  output  1  BRAM write enable
mem_wr_addr  output  ADDR_W  BRAM write address
mem_wr_din  output  DATA_W  BRAM write data
mem_rd_addr  output  ADDR_W  BRAM read address
mem_rd_dout  input  DATA_W  BRAM read data; valid the cycle after mem_rd_addr is sampled

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n=0.
- Reset values: state=S_LOAD; write and read counters 0; skid count 0; in-flight flag 0. Outputs: in_ready=0 while rst_n=0, out_valid=0, out_data=0, frame_done=0, mem_wr_en=0, mem_wr_addr=0, mem_rd_addr=0, mem_wr_din=0.
- FSM states:
  - S_LOAD: in_ready=1.
  - S_UNLOAD: in_ready=0.
- S_LOAD operation:
  - A transfer is in_valid & in_ready. mem_wr_en is combinational = in_valid & in_ready.
  - mem_wr_addr = wr_cnt; mem_wr_din = in_data.
  - wr_cnt increments per transfer.
  - On the transfer with wr_cnt==DEPTH-1: wr_cnt<=0 and state<=S_UNLOAD. No input is accepted in the following cycle.
- S_UNLOAD read issue:
  - Reads are issued at mem_rd_addr=rd_cnt when (skid_cnt + inflight) < 2 and rd_cnt < DEPTH.
  - An issued read sets inflight=1 for the next cycle.
  - In that next cycle mem_rd_dout is pushed into a 2-entry skid FIFO.
- Skid FIFO:
  - out_valid = (skid_cnt != 0); out_data = FIFO head (registered).
  - Pop on out_valid & out_ready. Push and pop in the same cycle leave skid_cnt unchanged.
- Throughput: with out_ready held 1, the output sustains 1 word/cycle. First out_valid appears 2 cycles after entering S_UNLOAD; no bubbles after that.
- Backpressure: out_ready=0 with 2 words held stalls issue. No word is dropped or duplicated; out_valid and out_data stay stable until accepted.
- Frame end:
  - The output transfer of word DEPTH-1 asserts frame_done for 1 cycle.
  - Same edge: state<=S_LOAD, rd_cnt<=0.
  - in_ready returns to 1 the next cycle.
- mem_rd_addr holds its last value when no read is issued. Stale rd_dout is never pushed (push is gated by inflight).
- No write and read hazard is possible: phases are exclusive.
- Reset mid-frame: returns to S_LOAD with empty skid FIFO. The partial frame is discarded and BRAM contents are left untouched.

Optional Feature:
- Macro: BRAM_STREAM_BITREV_EN.
- Defined: S_UNLOAD drives mem_rd_addr = bit-reverse of rd_cnt[ADDR_W-1:0], giving NTT natural/bit-reversed reordering. This requires DEPTH == 2**ADDR_W; otherwise compile-time $error.
- Not defined: mem_rd_addr = rd_cnt (natural order).
- Load side is identical in both builds.

Test Plan:
- Load 0..127 with in_valid=1 and out_ready=1 -> mem_wr_en for 128 cycles at addr 0..127. Output is 0..127 contiguous starting 2 cycles after S_UNLOAD entry. frame_done pulses with word 127.
- Random out_ready (50%) during drain -> exactly 128 words, in order, no duplicates. out_data is stable whenever out_valid=1 and out_ready=0.
- out_ready=0 for 10 cycles at drain start -> skid_cnt=2, mem_rd_addr frozen at 2. Release -> words 0,1,2,... resume without gap.
- in_valid gaps (every 3rd cycle low) during load -> write addresses still dense 0..127. in_ready drops exactly after word 127.
- rst_n low for 1 cycle after 40 words output -> out_valid=0 immediately, in_ready=1 after release. Next frame 1000..1127 is output intact.
- BRAM_STREAM_BITREV_EN build, load value=addr -> output sequence 0,64,32,96,16,...,127.
